// File: rtl/bcd_modn_counter_if.sv
// Control, load and status bundle for one bcd_modn_counter stage.
// The master drives requests and load data; the counter (slave) returns digits and flags.
interface bcd_modn_counter_if;
  logic       en;
  logic       up;
  logic       clr;
  logic       load;
  logic [3:0] load_hi;
  logic [3:0] load_lo;
  logic [3:0] count_hi;
  logic [3:0] count_lo;
  logic       tc;
  logic       co;
  logic       load_err;

  modport master (
    output en, up, clr, load, load_hi, load_lo,
    input  count_hi, count_lo, tc, co, load_err
  );

  modport slave (
    input  en, up, clr, load, load_hi, load_lo,
    output count_hi, count_lo, tc, co, load_err
  );
endinterface

// File: rtl/bcd_modn_counter.sv
// Two-digit BCD up/down counter over 0..MODULUS-1 with clear, parallel load,
// a combinational ripple enable for cascading and registered wrap/load-error pulses.
module bcd_modn_counter #(
  parameter int MODULUS = 60
) (
  input logic               clk,
  input logic               rst,
  bcd_modn_counter_if.slave bus
);

  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("bcd_modn_counter: MODULUS must be in 2..100");
  end

  localparam int         MAX_V  = MODULUS - 1;
  localparam logic [3:0] MAX_HI = 4'(MAX_V / 10);
  localparam logic [3:0] MAX_LO = 4'(MAX_V % 10);
  localparam logic [7:0] MOD_8  = 8'(MODULUS);

  logic [3:0] count_hi_q, count_hi_d;
  logic [3:0] count_lo_q, count_lo_d;
  logic       co_q, co_d;
  logic       load_err_q, load_err_d;
  logic [7:0] load_value;
  logic       load_ok;
  logic       at_max;
  logic       at_zero;

  // Wrap is decided on the full value, so non-decade moduli stop short of the next tens digit.
  assign at_max     = (count_hi_q == MAX_HI) && (count_lo_q == MAX_LO);
  assign at_zero    = (count_hi_q == 4'd0) && (count_lo_q == 4'd0);
  assign load_value = (8'd10 * {4'd0, bus.load_hi}) + {4'd0, bus.load_lo};
  assign load_ok    = (bus.load_hi <= 4'd9) && (bus.load_lo <= 4'd9) && (load_value < MOD_8);

  always_comb begin
    count_hi_d = count_hi_q;
    count_lo_d = count_lo_q;
    co_d       = 1'b0;
    load_err_d = 1'b0;
    if (bus.clr) begin
      count_hi_d = 4'd0;
      count_lo_d = 4'd0;
    end else if (bus.load) begin
      if (load_ok) begin
        count_hi_d = bus.load_hi;
        count_lo_d = bus.load_lo;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up) begin
        if (at_max) begin
          count_hi_d = 4'd0;
          count_lo_d = 4'd0;
          co_d       = 1'b1;
        end else if (count_lo_q == 4'd9) begin
          count_lo_d = 4'd0;
          count_hi_d = count_hi_q + 4'd1;
        end else begin
          count_lo_d = count_lo_q + 4'd1;
        end
      end else begin
        if (at_zero) begin
          count_hi_d = MAX_HI;
          count_lo_d = MAX_LO;
          co_d       = 1'b1;
        end else if (count_lo_q == 4'd0) begin
          count_lo_d = 4'd9;
          count_hi_d = count_hi_q - 4'd1;
        end else begin
          count_lo_d = count_lo_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_hi_q <= 4'd0;
      count_lo_q <= 4'd0;
      co_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_hi_q <= count_hi_d;
      count_lo_q <= count_lo_d;
      co_q       <= co_d;
      load_err_q <= load_err_d;
    end
  end

  // Ripple enable: high only in the cycle whose edge performs a counting wrap.
  assign bus.tc = bus.en & ~bus.clr & ~bus.load &
                  ((bus.up & at_max) | (~bus.up & at_zero));

  assign bus.count_hi = count_hi_q;
  assign bus.count_lo = count_lo_q;
  assign bus.co       = co_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_modn_counter.sv
// Directed bench for bcd_modn_counter: mod-60, mod-24 and mod-100 stages,
// with the mod-24 stage optionally cascaded from the mod-60 stage's ripple enable.
module tb_bcd_modn_counter;

  logic clk;
  logic rst;
  logic casc;
  logic en24;
  int   errors;
  int   checks;

  bcd_modn_counter_if if60 ();
  bcd_modn_counter_if if24 ();
  bcd_modn_counter_if if100 ();

  bcd_modn_counter #(.MODULUS(60))  dut60  (.clk(clk), .rst(rst), .bus(if60));
  bcd_modn_counter #(.MODULUS(24))  dut24  (.clk(clk), .rst(rst), .bus(if24));
  bcd_modn_counter #(.MODULUS(100)) dut100 (.clk(clk), .rst(rst), .bus(if100));

  assign if24.en = casc ? if60.tc : en24;

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({if60.count_hi, if60.count_lo} !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_count got=%h exp=00", {if60.count_hi, if60.count_lo});
    end
    checks++;
    if ({if60.co, if60.load_err, if60.tc} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags got co/err/tc=%b exp=000", {if60.co, if60.load_err, if60.tc});
    end
    if60.en = 1'b1; if60.up = 1'b0;
    #1;
    checks++;
    if (if60.tc !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_tc_down got=%b exp=1", if60.tc);
    end
    if60.en = 1'b0; if60.up = 1'b1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_count_up();
    int e;
    e = 0;
    if60.en = 1'b1; if60.up = 1'b1;
    #1;
    for (int i = 0; i < 60; i++) begin
      checks++;
      if (if60.tc !== (e == 59)) begin
        errors++; $display("[TB] FAIL up_tc at V=%0d got=%b exp=%b", e, if60.tc, (e == 59));
      end
      tick();
      e = (e + 1) % 60;
      checks++;
      if ({if60.count_hi, if60.count_lo} !== {4'(e / 10), 4'(e % 10)}) begin
        errors++; $display("[TB] FAIL up_count got=%h exp=%0d", {if60.count_hi, if60.count_lo}, e);
      end
      checks++;
      if (if60.co !== (e == 0)) begin
        errors++; $display("[TB] FAIL up_co at V=%0d got=%b exp=%b", e, if60.co, (e == 0));
      end
    end
    if60.en = 1'b0;
  endtask

  task automatic test_count_down();
    if60.en = 1'b1; if60.up = 1'b0;
    #1;
    checks++;
    if (if60.tc !== 1'b1) begin
      errors++; $display("[TB] FAIL down_tc got=%b exp=1", if60.tc);
    end
    tick();
    checks++;
    if ({if60.count_hi, if60.count_lo, if60.co} !== {8'h59, 1'b1}) begin
      errors++; $display("[TB] FAIL down_wrap got=%h co=%b exp=59 co=1", {if60.count_hi, if60.count_lo}, if60.co);
    end
    tick();
    checks++;
    if ({if60.count_hi, if60.count_lo, if60.co} !== {8'h58, 1'b0}) begin
      errors++; $display("[TB] FAIL down_step got=%h co=%b exp=58 co=0", {if60.count_hi, if60.count_lo}, if60.co);
    end
    if60.en = 1'b0;
  endtask

  task automatic test_load();
    if60.load = 1'b1; if60.load_hi = 4'd4; if60.load_lo = 4'd5;
    tick();
    checks++;
    if ({if60.count_hi, if60.count_lo, if60.co, if60.load_err} !== {8'h45, 2'b00}) begin
      errors++; $display("[TB] FAIL load_45 got=%h co=%b err=%b exp=45 0 0", {if60.count_hi, if60.count_lo}, if60.co, if60.load_err);
    end
    if60.load_hi = 4'd7; if60.load_lo = 4'd0;
    tick();
    checks++;
    if ({if60.count_hi, if60.count_lo, if60.load_err} !== {8'h45, 1'b1}) begin
      errors++; $display("[TB] FAIL load_70_rejected got=%h err=%b exp=45 1", {if60.count_hi, if60.count_lo}, if60.load_err);
    end
    if60.load = 1'b0;
    tick();
    checks++;
    if (if60.load_err !== 1'b0) begin
      errors++; $display("[TB] FAIL load_err_one_cycle got=%b exp=0", if60.load_err);
    end
    if60.load = 1'b1; if60.load_hi = 4'd3; if60.load_lo = 4'hA;
    tick();
    checks++;
    if ({if60.count_hi, if60.count_lo, if60.load_err} !== {8'h45, 1'b1}) begin
      errors++; $display("[TB] FAIL load_3A_rejected got=%h err=%b exp=45 1", {if60.count_hi, if60.count_lo}, if60.load_err);
    end
    if60.load_hi = 4'd5; if60.load_lo = 4'd9;
    tick();
    checks++;
    if ({if60.count_hi, if60.count_lo, if60.load_err} !== {8'h59, 1'b0}) begin
      errors++; $display("[TB] FAIL load_59 got=%h err=%b exp=59 0", {if60.count_hi, if60.count_lo}, if60.load_err);
    end
    if60.load = 1'b0;
  endtask

  task automatic test_priority();
    if60.clr = 1'b1; if60.load = 1'b1; if60.load_hi = 4'd2; if60.load_lo = 4'd2;
    if60.en = 1'b1; if60.up = 1'b1;
    #1;
    checks++;
    if (if60.tc !== 1'b0) begin
      errors++; $display("[TB] FAIL prio_tc got=%b exp=0", if60.tc);
    end
    tick();
    checks++;
    if ({if60.count_hi, if60.count_lo, if60.co, if60.load_err} !== {8'h00, 2'b00}) begin
      errors++; $display("[TB] FAIL prio_clr got=%h co=%b err=%b exp=00 0 0", {if60.count_hi, if60.count_lo}, if60.co, if60.load_err);
    end
    if60.load_hi = 4'hA;
    tick();
    checks++;
    if ({if60.count_hi, if60.count_lo, if60.load_err} !== {8'h00, 1'b0}) begin
      errors++; $display("[TB] FAIL prio_clr_bad_load got=%h err=%b exp=00 0", {if60.count_hi, if60.count_lo}, if60.load_err);
    end
    if60.clr = 1'b0; if60.load_hi = 4'd5; if60.load_lo = 4'd9; if60.en = 1'b0;
    tick();
    if60.load_hi = 4'd1; if60.load_lo = 4'd0; if60.en = 1'b1;
    #1;
    checks++;
    if (if60.tc !== 1'b0) begin
      errors++; $display("[TB] FAIL load_at_tc_tc got=%b exp=0", if60.tc);
    end
    tick();
    checks++;
    if ({if60.count_hi, if60.count_lo, if60.co} !== {8'h10, 1'b0}) begin
      errors++; $display("[TB] FAIL load_beats_wrap got=%h co=%b exp=10 0", {if60.count_hi, if60.count_lo}, if60.co);
    end
    if60.load = 1'b0; if60.up = 1'b0;
    tick();
    checks++;
    if ({if60.count_hi, if60.count_lo} !== 8'h09) begin
      errors++; $display("[TB] FAIL dir_down_borrow got=%h exp=09", {if60.count_hi, if60.count_lo});
    end
    if60.up = 1'b1;
    tick();
    checks++;
    if ({if60.count_hi, if60.count_lo} !== 8'h10) begin
      errors++; $display("[TB] FAIL dir_up_carry got=%h exp=10", {if60.count_hi, if60.count_lo});
    end
    if60.en = 1'b0;
  endtask

  task automatic test_mod24();
    logic [7:0] seq [5];
    seq[0] = 8'h20; seq[1] = 8'h21; seq[2] = 8'h22; seq[3] = 8'h23; seq[4] = 8'h00;
    if24.load = 1'b1; if24.load_hi = 4'd2; if24.load_lo = 4'd4;
    tick();
    checks++;
    if ({if24.count_hi, if24.count_lo, if24.load_err} !== {8'h00, 1'b1}) begin
      errors++; $display("[TB] FAIL m24_load_24_rejected got=%h err=%b exp=00 1", {if24.count_hi, if24.count_lo}, if24.load_err);
    end
    if24.load_hi = 4'd1; if24.load_lo = 4'd9;
    tick();
    checks++;
    if ({if24.count_hi, if24.count_lo} !== 8'h19) begin
      errors++; $display("[TB] FAIL m24_load_19 got=%h exp=19", {if24.count_hi, if24.count_lo});
    end
    if24.load = 1'b0; en24 = 1'b1; if24.up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({if24.count_hi, if24.count_lo, if24.co} !== {seq[i], (i == 4)}) begin
        errors++; $display("[TB] FAIL m24_seq step=%0d got=%h co=%b exp=%h co=%b", i, {if24.count_hi, if24.count_lo}, if24.co, seq[i], (i == 4));
      end
    end
    en24 = 1'b0;
  endtask

  task automatic test_cascade();
    if60.clr = 1'b1; if24.clr = 1'b1;
    tick();
    if60.clr = 1'b0; if24.clr = 1'b0;
    casc = 1'b1; if60.en = 1'b1; if60.up = 1'b1; if24.up = 1'b1;
    for (int k = 1; k <= 125; k++) begin
      tick();
      checks++;
      if ({if24.count_hi, if24.count_lo} !== {4'd0, 4'(k / 60)}) begin
        errors++; $display("[TB] FAIL cascade_upper edge=%0d got=%h exp=%0d", k, {if24.count_hi, if24.count_lo}, k / 60);
      end
    end
    checks++;
    if ({if60.count_hi, if60.count_lo} !== 8'h05) begin
      errors++; $display("[TB] FAIL cascade_lower got=%h exp=05", {if60.count_hi, if60.count_lo});
    end
    casc = 1'b0; if60.en = 1'b0;
  endtask

  task automatic test_mod100();
    if100.load = 1'b1; if100.load_hi = 4'd9; if100.load_lo = 4'd9;
    tick();
    if100.load = 1'b0; if100.en = 1'b1; if100.up = 1'b1;
    #1;
    checks++;
    if ({if100.count_hi, if100.count_lo, if100.tc} !== {8'h99, 1'b1}) begin
      errors++; $display("[TB] FAIL m100_at_99 got=%h tc=%b exp=99 1", {if100.count_hi, if100.count_lo}, if100.tc);
    end
    tick();
    checks++;
    if ({if100.count_hi, if100.count_lo, if100.co} !== {8'h00, 1'b1}) begin
      errors++; $display("[TB] FAIL m100_up_wrap got=%h co=%b exp=00 1", {if100.count_hi, if100.count_lo}, if100.co);
    end
    if100.up = 1'b0;
    tick();
    checks++;
    if ({if100.count_hi, if100.count_lo, if100.co} !== {8'h99, 1'b1}) begin
      errors++; $display("[TB] FAIL m100_down_wrap got=%h co=%b exp=99 1", {if100.count_hi, if100.count_lo}, if100.co);
    end
    if100.en = 1'b0;
    tick();
    checks++;
    if ({if100.count_hi, if100.count_lo, if100.co} !== {8'h99, 1'b0}) begin
      errors++; $display("[TB] FAIL m100_hold got=%h co=%b exp=99 0", {if100.count_hi, if100.count_lo}, if100.co);
    end
  endtask

  task automatic test_async_reset();
    if60.load = 1'b1; if60.load_hi = 4'd5; if60.load_lo = 4'd9;
    tick();
    if60.load = 1'b0; if60.en = 1'b1; if60.up = 1'b1;
    tick();
    if60.en = 1'b0;
    checks++;
    if ({if60.count_hi, if60.count_lo, if60.co} !== {8'h00, 1'b1}) begin
      errors++; $display("[TB] FAIL arst_pre_co got=%h co=%b exp=00 1", {if60.count_hi, if60.count_lo}, if60.co);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (if60.co !== 1'b0) begin
      errors++; $display("[TB] FAIL arst_drop_co got=%b exp=0", if60.co);
    end
    @(negedge clk);
    rst = 1'b1;
    if60.load = 1'b1; if60.load_hi = 4'd3; if60.load_lo = 4'd7;
    tick();
    if60.load = 1'b0;
    checks++;
    if ({if60.count_hi, if60.count_lo} !== 8'h37) begin
      errors++; $display("[TB] FAIL arst_load_37 got=%h exp=37", {if60.count_hi, if60.count_lo});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({if60.count_hi, if60.count_lo, if60.co, if60.load_err} !== 10'd0) begin
      errors++; $display("[TB] FAIL arst_immediate got=%h co=%b err=%b exp=00 0 0", {if60.count_hi, if60.count_lo}, if60.co, if60.load_err);
    end
    if60.en = 1'b1; if60.up = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if ({if60.count_hi, if60.count_lo} !== 8'h01) begin
      errors++; $display("[TB] FAIL arst_first_count got=%h exp=01", {if60.count_hi, if60.count_lo});
    end
    if60.en = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; casc = 1'b0; en24 = 1'b0;
    errors = 0; checks = 0;
    if60.en = 1'b0;  if60.up = 1'b1;  if60.clr = 1'b0;  if60.load = 1'b0;
    if60.load_hi = 4'd0;  if60.load_lo = 4'd0;
    if24.up = 1'b1;  if24.clr = 1'b0;  if24.load = 1'b0;
    if24.load_hi = 4'd0;  if24.load_lo = 4'd0;
    if100.en = 1'b0; if100.up = 1'b1; if100.clr = 1'b0; if100.load = 1'b0;
    if100.load_hi = 4'd0; if100.load_lo = 4'd0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_priority();
    test_mod24();
    test_cascade();
    test_mod100();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
